// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
// Holds the FSM state type, accumulator width rule and result reduction.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FLUSH,
    OUT
  } state_t;

  // Accumulator width: product width plus growth for K terms.
  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

  // Clamp to the ow-bit signed range when sat is set; otherwise pass
  // through so the caller's truncation wraps in two's complement.
  function automatic logic signed [63:0] fit(
    input logic signed [63:0] v,
    input int                 ow,
    input bit                 sat
  );
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    if (sat && v > mx) return mx;
    if (sat && v < mn) return mn;
    return v;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Two-stage signed multiply-accumulate: registered product, then accumulate.
// Ports: clk, reset (sync, active-low), clr, en, a, b in; acc out.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DW    = 8,
  parameter int K     = 4,
  parameter int ACC_W = acc_w(DW, K)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0] prod;
  logic                 pv;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod <= '0;
      pv   <= 1'b0;
      acc  <= '0;
    end else begin
      prod <= PW'(a) * PW'(b);
      pv   <= en;
      if (clr) acc <= '0;
      else if (pv) acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Computes C = A x B from internal operand stores, streaming C row-major.
// Ports: clk, reset, wr_* store writes, start, busy, done, c_* stream.
// Option MATMUL_ENGINE_SAT_EN: clamp results instead of wrapping.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter  int M     = 4,
  parameter  int K     = 4,
  parameter  int N     = 4,
  parameter  int DW    = 8,
  parameter  int OUT_W = 16,
  localparam int MX    = (M * K > K * N) ? M * K : K * N,
  localparam int AW    = (MX > 1) ? $clog2(MX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [OUT_W-1:0] c_data,
  output logic             c_last
);

`ifdef MATMUL_ENGINE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int ACC_W = acc_w(DW, K);
  localparam int AIW   = (M * K > 1) ? $clog2(M * K) : 1;
  localparam int BIW   = (K * N > 1) ? $clog2(K * N) : 1;
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int JW    = (N > 1) ? $clog2(N) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  logic signed [DW-1:0] a_mem [0:M*K-1];
  logic signed [DW-1:0] b_mem [0:K*N-1];

  state_t             state;
  logic [IW-1:0]      i;
  logic [JW-1:0]      j;
  logic [KW-1:0]      k;
  logic               fl;
  logic [AIW-1:0]     a_idx;
  logic [BIW-1:0]     b_idx;
  logic               clr;
  logic               en;
  logic signed [ACC_W-1:0] acc;

  // Stores are deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && wr_en && !busy) begin
      if (!wr_sel && int'(wr_addr) < M * K)
        a_mem[wr_addr[AIW-1:0]] <= wr_data;
      if (wr_sel && int'(wr_addr) < K * N)
        b_mem[wr_addr[BIW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    a_idx = AIW'(int'(i) * K + int'(k));
    b_idx = BIW'(int'(k) * N + int'(j));
    en    = (state == MAC);
    // Clear on a new run and on each element handshake.
    clr   = (state == IDLE && start) || (state == OUT && c_ready);
  end

  mac_unit #(
    .DW   (DW),
    .K    (K),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .a    (a_mem[a_idx]),
    .b    (b_mem[b_idx]),
    .acc  (acc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      c_valid <= 1'b0;
      c_last  <= 1'b0;
      c_data  <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      fl      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= MAC;
            busy  <= 1'b1;
            i     <= '0;
            j     <= '0;
            k     <= '0;
          end
        end
        MAC: begin
          if (k == K_LAST) begin
            k     <= '0;
            fl    <= 1'b0;
            state <= FLUSH;
          end else begin
            k <= k + 1'b1;
          end
        end
        // Two cycles drain the product register into the accumulator.
        FLUSH: begin
          if (fl) begin
            state   <= OUT;
            c_valid <= 1'b1;
            c_data  <= OUT_W'(fit(64'(acc), OUT_W, SAT));
            c_last  <= (i == I_LAST) && (j == J_LAST);
          end else begin
            fl <= 1'b1;
          end
        end
        OUT: begin
          if (c_ready) begin
            c_valid <= 1'b0;
            c_last  <= 1'b0;
            if (c_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              i     <= '0;
              j     <= '0;
            end else begin
              state <= MAC;
              if (j == J_LAST) begin
                j <= '0;
                i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed testbench for matmul_engine: 2x2x2 instance and 4x4x4 instance.
// Covers reset, results, stalls, busy-ignore, mid-run reset and saturation.
module tb_matmul_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        wr_en2 = 0, wr_sel2 = 0, start2 = 0, c_ready2 = 1;
  logic [1:0]  wr_addr2 = '0;
  logic [7:0]  wr_data2 = '0;
  logic        busy2, done2, c_valid2, c_last2;
  logic [15:0] c_data2;

  logic        wr_en4 = 0, wr_sel4 = 0, start4 = 0, c_ready4 = 1;
  logic [3:0]  wr_addr4 = '0;
  logic [7:0]  wr_data4 = '0;
  logic        busy4, done4, c_valid4, c_last4;
  logic [15:0] c_data4;

  matmul_engine #(.M(2), .K(2), .N(2), .DW(8), .OUT_W(16)) d2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_sel(wr_sel2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .start(start2),
    .busy(busy2), .done(done2), .c_valid(c_valid2), .c_ready(c_ready2),
    .c_data(c_data2), .c_last(c_last2)
  );

  matmul_engine d4 (
    .clk(clk), .reset(reset), .wr_en(wr_en4), .wr_sel(wr_sel4),
    .wr_addr(wr_addr4), .wr_data(wr_data4), .start(start4),
    .busy(busy4), .done(done4), .c_valid(c_valid4), .c_ready(c_ready4),
    .c_data(c_data4), .c_last(c_last4)
  );

  logic [15:0] got2 [4];
  logic [3:0]  lst2;
  int          n2;
  int          dcyc2;
  bit          stab2;
  bit          tmo2;
  logic        busy_c1;

  task automatic write2(input logic sel, input int addr, input int val);
    @(negedge clk);
    wr_en2   = 1'b1;
    wr_sel2  = sel;
    wr_addr2 = 2'(addr);
    wr_data2 = 8'(val);
    @(negedge clk);
    wr_en2 = 1'b0;
  endtask

  task automatic load2(input int a0, a1, a2, a3, b0, b1, b2, b3);
    write2(0, 0, a0); write2(0, 1, a1); write2(0, 2, a2); write2(0, 3, a3);
    write2(1, 0, b0); write2(1, 1, b1); write2(1, 2, b2); write2(1, 3, b3);
  endtask

  // Runs one computation on d2, collecting outputs; no comparisons here.
  task automatic run2(input int stall, input bit poke);
    int sc;
    logic [15:0] first;
    sc = 0; n2 = 0; dcyc2 = -1; stab2 = 1; tmo2 = 1; lst2 = '0;
    first = '0;
    @(negedge clk);
    start2   = 1'b1;
    c_ready2 = (stall == 0);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        start2  = 1'b0;
        busy_c1 = busy2;
      end
      if (poke && cyc == 3) begin
        start2 = 1'b1; wr_en2 = 1'b1; wr_sel2 = 1'b0;
        wr_addr2 = 2'd0; wr_data2 = 8'd99;
      end
      if (poke && cyc == 5) begin
        start2 = 1'b0; wr_en2 = 1'b0;
      end
      if (done2) begin
        dcyc2 = cyc;
        tmo2  = 0;
        break;
      end
      if (c_valid2) begin
        if (sc == 0) first = c_data2;
        else if (c_data2 !== first) stab2 = 0;
        if (sc < stall) begin
          c_ready2 = 1'b0;
          sc++;
        end else begin
          c_ready2 = 1'b1;
          if (n2 < 4) begin
            got2[n2] = c_data2;
            lst2[n2] = c_last2;
          end
          n2++;
          sc = 0;
        end
      end else begin
        c_ready2 = (stall == 0);
      end
    end
    start2 = 1'b0; wr_en2 = 1'b0; c_ready2 = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start2 = 1'b1;
    start4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy2 !== 1'b0 || c_valid2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b valid=%b done=%b expected 0 0 0",
               busy2, c_valid2, done2);
    end
    checks++;
    if (c_data2 !== 16'd0 || c_last2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: data=%0d last=%b expected 0 0",
               c_data2, c_last2);
    end
    @(negedge clk);
    reset = 1'b1;
    start2 = 1'b0;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy2 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy2=%b busy4=%b expected 0 0",
               busy2, busy4);
    end
  endtask

  task automatic test_signed;
    int exp [4];
    exp = '{9, 22, -13, -50};
    load2(-1, 2, 3, -4, 5, -6, 7, 8);
    run2(0, 0);
    checks++;
    if (tmo2) begin
      errors++;
      $display("FAIL signed_timeout: done=%0d expected 1", 0);
    end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got2[e] !== 16'(exp[e])) begin
        errors++;
        $display("FAIL signed_c%0d: got %0d expected %0d",
                 e, $signed(got2[e]), exp[e]);
      end
    end
  endtask

  task automatic test_basic;
    int exp [4];
    exp = '{19, 22, 43, 50};
    load2(1, 2, 3, 4, 5, 6, 7, 8);
    run2(0, 0);
    checks++;
    if (busy_c1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b expected 1", busy_c1);
    end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got2[e] !== 16'(exp[e])) begin
        errors++;
        $display("FAIL basic_c%0d: got %0d expected %0d",
                 e, $signed(got2[e]), exp[e]);
      end
    end
    checks++;
    if (lst2 !== 4'b1000 || n2 != 4) begin
      errors++;
      $display("FAIL basic_last: got %b n=%0d expected 1000 n=4", lst2, n2);
    end
    checks++;
    if (dcyc2 != 21) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d expected 21", dcyc2);
    end
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_fall: got %b expected 0", busy2);
    end
  endtask

  task automatic test_stall;
    int exp [4];
    exp = '{19, 22, 43, 50};
    run2(3, 0);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got2[e] !== 16'(exp[e])) begin
        errors++;
        $display("FAIL stall_c%0d: got %0d expected %0d",
                 e, $signed(got2[e]), exp[e]);
      end
    end
    checks++;
    if (stab2 !== 1'b1) begin
      errors++;
      $display("FAIL stall_stable: got %b expected 1", stab2);
    end
    checks++;
    if (dcyc2 != 33 || lst2 !== 4'b1000) begin
      errors++;
      $display("FAIL stall_done: cycle %0d last %b expected 33 1000",
               dcyc2, lst2);
    end
  endtask

  task automatic test_back_to_back;
    int exp [4];
    exp = '{19, 22, 43, 50};
    for (int r = 0; r < 2; r++) begin
      run2(0, r == 0);
      for (int e = 0; e < 4; e++) begin
        checks++;
        if (got2[e] !== 16'(exp[e])) begin
          errors++;
          $display("FAIL busy_ignore_r%0d_c%0d: got %0d expected %0d",
                   r, e, $signed(got2[e]), exp[e]);
        end
      end
      checks++;
      if (dcyc2 != 21) begin
        errors++;
        $display("FAIL busy_ignore_r%0d_done: got %0d expected 21", r, dcyc2);
      end
    end
  endtask

  task automatic test_reset_mid;
    int exp [4];
    exp = '{19, 22, 43, 50};
    @(negedge clk);
    start2   = 1'b1;
    c_ready2 = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start2 = 1'b0;
    end
    reset  = 1'b0;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy2 !== 1'b0 || c_valid2 !== 1'b0 || done2 !== 1'b0 ||
        c_data2 !== 16'd0 || c_last2 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out: busy=%b valid=%b done=%b data=%0d last=%b expected all 0",
               busy2, c_valid2, done2, c_data2, c_last2);
    end
    @(negedge clk);
    reset  = 1'b1;
    start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b expected 0", busy2);
    end
    run2(0, 0);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (got2[e] !== 16'(exp[e])) begin
        errors++;
        $display("FAIL midreset_c%0d: got %0d expected %0d",
                 e, $signed(got2[e]), exp[e]);
      end
    end
    checks++;
    if (dcyc2 != 21 || lst2 !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_done: cycle %0d last %b expected 21 1000",
               dcyc2, lst2);
    end
  endtask

  task automatic test_saturate;
    logic [15:0] exp;
    int n;
    int dc;
`ifdef MATMUL_ENGINE_SAT_EN
    exp = 16'h7fff;
`else
    exp = 16'h0000;
`endif
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        @(negedge clk);
        wr_en4   = 1'b1;
        wr_sel4  = s[0];
        wr_addr4 = 4'(a);
        wr_data4 = 8'h80;
      end
    end
    @(negedge clk);
    wr_en4 = 1'b0;
    start4 = 1'b1;
    c_ready4 = 1'b1;
    n = 0;
    dc = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start4 = 1'b0;
      if (done4) begin
        dc = cyc;
        break;
      end
      if (c_valid4) begin
        checks++;
        if (c_data4 !== exp) begin
          errors++;
          $display("FAIL sat_c%0d: got %0d expected %0d",
                   n, $signed(c_data4), $signed(exp));
        end
        n++;
      end
    end
    checks++;
    if (dc != 113 || n != 16) begin
      errors++;
      $display("FAIL sat_done: cycle %0d count %0d expected 113 16", dc, n);
    end
  endtask

  initial begin
    test_reset;
    test_signed;
    test_basic;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_saturate;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
